// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access path.
// Holds access-size encodings, the 128-bit-load selector, FSM state
// encodings, byte-enable lookup constants and sign-extension helpers.
package mem_pkg;

  // ByteSel encodings (2'b11 falls through to word handling)
  localparam logic [1:0] BS_WORD = 2'b00;
  localparam logic [1:0] BS_BYTE = 2'b01;
  localparam logic [1:0] BS_HALF = 2'b10;

  // L16B value that requests a four-beat 128-bit load
  localparam logic [1:0] L16B_VEC = 2'b01;

  // Byte-enable lookup constants
  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for a 32-bit little-endian bus.
// Ports:
//   size       - access size (mem_pkg BS_* encodings, 2'b11 = word)
//   addr_lo    - Address[1:0]; bit 0 ignored for halfwords
//   store_data - right-justified store data
//   load_word  - raw bus word for loads
//   be         - store byte enables (bit i = lane i)
//   bus_wdata  - store data replicated onto all lanes
//   load_ext   - selected load lane, sign-extended to 32 bits
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_ext
);

  logic [31:0] shifted_s;

  // Move the addressed lane down to bit 0 for byte extraction
  assign shifted_s = load_word >> {addr_lo, 3'b000};

  // Byte enables, replicated store data and extended load data per size
  always_comb begin
    be        = BE_ALL;
    bus_wdata = store_data;
    load_ext  = load_word;
    case (size)
      BS_BYTE: begin
        be        = BE_BYTE0 << addr_lo;
        bus_wdata = {4{store_data[7:0]}};
        load_ext  = sext8(shifted_s[7:0]);
      end
      BS_HALF: begin
        be        = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
        bus_wdata = {2{store_data[15:0]}};
        load_ext  = addr_lo[1] ? sext16(load_word[31:16]) : sext16(load_word[15:0]);
      end
      default: begin
        be        = BE_ALL;
        bus_wdata = store_data;
        load_ext  = load_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Initiator-side load/store sequencer for a single-port 32-bit valid/ack bus.
// Accepts one request at a time, stalls the pipeline while busy, serialises
// 128-bit loads into four word beats and aborts a beat after TIMEOUT cycles.
// Ports:
//   Clock/Reset         - rising-edge clock, async active-high reset
//   Req_Valid..WriteData - pipeline request
//   Stall/Done/Err      - pipeline handshake (Done/Err one-cycle pulses)
//   ReadData/ReadData128 - load results, held until the next read completes
//   Mem_*               - memory bus
module mem_access_sequencer
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req_Valid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        ByteSel,
  input  logic [1:0]        L16B,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic              Stall,
  output logic              Done,
  output logic              Err,
  output logic [31:0]       ReadData,
  output logic [127:0]      ReadData128,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WData,
  output logic [3:0]        Mem_BE,
  input  logic              Mem_Ack,
  input  logic [31:0]       Mem_RData
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t              state_r, state_nxt_s;
  logic                accept_s, busy_s, ack_s, last_beat_s, timeout_s;
  logic                we_r, is128_r, done_r, err_r;
  logic [1:0]          size_r, size_eff_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r, load_word_s, load_ext_s, bus_wdata_s;
  logic [3:0]          be_s;
  logic [2:0]          beat_cnt_r;
  logic [7:0]          tmo_cnt_r;
  logic [127:0]        buf_r, buf_nxt_s, rd128_r;
  logic [31:0]         rd_data_r;

  assign busy_s      = (state_r == ST_BUSY);
  assign ack_s       = busy_s & Mem_Ack;
  assign last_beat_s = is128_r ? (beat_cnt_r == 3'd3) : 1'b1;
  assign timeout_s   = busy_s & ~Mem_Ack & (tmo_cnt_r == TMO_LAST);

  // Next-state logic and request acceptance
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Req_Valid && (MemRead || MemWrite)) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if ((ack_s && last_beat_s) || timeout_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Drop the incoming bus word into the lane for the current beat
  always_comb begin
    buf_nxt_s = buf_r;
    case (beat_cnt_r[1:0])
      2'd0:    buf_nxt_s[31:0]   = Mem_RData;
      2'd1:    buf_nxt_s[63:32]  = Mem_RData;
      2'd2:    buf_nxt_s[95:64]  = Mem_RData;
      default: buf_nxt_s[127:96] = Mem_RData;
    endcase
  end

  // A 128-bit load reports beat 0 unextended in ReadData
  assign size_eff_s  = is128_r ? BS_WORD : size_r;
  assign load_word_s = is128_r ? buf_nxt_s[31:0] : Mem_RData;

  mem_lane_align u_align (
    .size       (size_eff_s),
    .addr_lo    (addr_r[1:0]),
    .store_data (wdata_r),
    .load_word  (load_word_s),
    .be         (be_s),
    .bus_wdata  (bus_wdata_s),
    .load_ext   (load_ext_s)
  );

  // Request latch, beat/timeout counters and result registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      we_r       <= 1'b0;
      is128_r    <= 1'b0;
      size_r     <= 2'b00;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= 32'h0;
      beat_cnt_r <= 3'd0;
      tmo_cnt_r  <= 8'd0;
      buf_r      <= 128'h0;
      rd128_r    <= 128'h0;
      rd_data_r  <= 32'h0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == ST_DONE);
      err_r  <= timeout_s;
      if (accept_s) begin
        we_r       <= MemWrite;
        is128_r    <= ~MemWrite & (L16B == L16B_VEC);
        size_r     <= ByteSel;
        addr_r     <= Address;
        wdata_r    <= WriteData;
        beat_cnt_r <= 3'd0;
        tmo_cnt_r  <= 8'd0;
        buf_r      <= 128'h0;
      end else if (ack_s) begin
        buf_r      <= buf_nxt_s;
        beat_cnt_r <= beat_cnt_r + 3'd1;
        tmo_cnt_r  <= 8'd0;
        // Results change only when a read finishes, so stores leave them intact
        if (last_beat_s && !we_r) begin
          rd_data_r <= load_ext_s;
          rd128_r   <= buf_nxt_s;
        end else begin
          rd_data_r <= rd_data_r;
        end
      end else if (timeout_s) begin
        tmo_cnt_r <= 8'd0;
        rd_data_r <= 32'h0;
        rd128_r   <= 128'h0;
      end else if (busy_s) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end
  end

  assign Stall       = accept_s | busy_s;
  assign Done        = done_r;
  assign Err         = err_r;
  assign ReadData    = rd_data_r;
  assign ReadData128 = rd128_r;

  // Bus fields are derived from latched state so they stay stable until ack
  assign Mem_Req   = busy_s;
  assign Mem_We    = busy_s & we_r;
  assign Mem_BE    = busy_s ? (we_r ? be_s : BE_ALL) : 4'b0000;
  assign Mem_WData = (busy_s & we_r) ? bus_wdata_s : 32'h0;
  assign Mem_Addr  = !busy_s ? {ADDR_W{1'b0}} :
                     is128_r ? {addr_r[ADDR_W-1:4], beat_cnt_r[1:0], 2'b00} :
                               {addr_r[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Req_Valid, MemRead, MemWrite, Mem_Ack;
  logic [1:0]   ByteSel, L16B;
  logic [31:0]  Address, WriteData, Mem_RData;
  logic         Stall, Done, Err, Mem_Req, Mem_We;
  logic [31:0]  ReadData, Mem_Addr, Mem_WData;
  logic [127:0] ReadData128;
  logic [3:0]   Mem_BE;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd;

  always #5 Clock = ~Clock;

  mem_access_sequencer #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .Req_Valid(Req_Valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .ByteSel(ByteSel), .L16B(L16B), .Address(Address),
    .WriteData(WriteData), .Stall(Stall), .Done(Done), .Err(Err),
    .ReadData(ReadData), .ReadData128(ReadData128), .Mem_Req(Mem_Req),
    .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_BE(Mem_BE), .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData)
  );

  typedef struct {
    logic        we;
    logic        rd;
    logic [1:0]  bs;
    logic [1:0]  l16;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Req_Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    ByteSel = 2'b00; L16B = 2'b00; Address = 32'h0; WriteData = 32'h0;
  endtask

  // Single-beat transaction with Mem_Ack high; checks cycles 0..3
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge Clock);
    Req_Valid = 1'b1; MemRead = v.rd; MemWrite = v.we; ByteSel = v.bs;
    L16B = v.l16; Address = v.addr; WriteData = v.wdata;
    Mem_Ack = 1'b1; Mem_RData = v.rdata;
    #1 chk($sformatf("v%0d_stall0", idx), {127'b0, Stall}, 128'd1);
    @(negedge Clock);
    idle_inputs();
    chk($sformatf("v%0d_req", idx),   {127'b0, Mem_Req}, 128'd1);
    chk($sformatf("v%0d_stall1", idx), {127'b0, Stall}, 128'd1);
    chk($sformatf("v%0d_addr", idx),  {96'b0, Mem_Addr}, {96'b0, v.e_addr});
    chk($sformatf("v%0d_be", idx),    {124'b0, Mem_BE}, {124'b0, v.e_be});
    chk($sformatf("v%0d_we", idx),    {127'b0, Mem_We}, {127'b0, v.we});
    if (v.we) chk($sformatf("v%0d_wdata", idx), {96'b0, Mem_WData}, {96'b0, v.e_wdata});
    else      last_rd = v.e_rdata;
    @(negedge Clock);
    chk($sformatf("v%0d_done", idx),  {126'b0, Done, Err}, 128'd2);
    chk($sformatf("v%0d_stall2", idx), {126'b0, Stall, Mem_Req}, 128'd0);
    chk($sformatf("v%0d_rdata", idx), {96'b0, ReadData}, {96'b0, last_rd});
    @(negedge Clock);
    chk($sformatf("v%0d_done_pulse", idx), {127'b0, Done}, 128'd0);
  endtask

  initial begin
    int req_cnt;
    logic done_seen;
    logic [31:0] rd_words [4];

    vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 32'h104, 32'hDEADBEEF, 32'h0,        32'h104, 4'b1111, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 2'b01, 2'b00, 32'h203, 32'h0,        32'h80112233, 32'h200, 4'b1111, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 2'b10, 2'b00, 32'h302, 32'h0000ABCD, 32'h0,        32'h300, 4'b1100, 32'hABCDABCD, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 2'b10, 2'b00, 32'h501, 32'h0,        32'h12348765, 32'h500, 4'b1111, 32'h0,        32'hFFFF8765};
    vecs[4]  = '{1'b1, 1'b0, 2'b01, 2'b00, 32'h601, 32'h000000A5, 32'h0,        32'h600, 4'b0010, 32'hA5A5A5A5, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 2'b00, 32'h70C, 32'h0,        32'hCAFEF00D, 32'h70C, 4'b1111, 32'h0,        32'hCAFEF00D};
    vecs[6]  = '{1'b0, 1'b1, 2'b01, 2'b00, 32'h802, 32'h0,        32'h007F0000, 32'h800, 4'b1111, 32'h0,        32'h0000007F};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 2'b00, 32'h90E, 32'h0,        32'h7ABC0001, 32'h90C, 4'b1111, 32'h0,        32'h00007ABC};
    vecs[8]  = '{1'b0, 1'b1, 2'b11, 2'b00, 32'hA02, 32'h0,        32'h13579BDF, 32'hA00, 4'b1111, 32'h0,        32'h13579BDF};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 2'b00, 32'hB04, 32'h01020304, 32'h99999999, 32'hB04, 4'b1111, 32'h01020304, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 2'b01, 2'b01, 32'hC03, 32'h00000077, 32'h0,        32'hC00, 4'b1000, 32'h77777777, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 2'b00, 2'b00, 32'hE08, 32'h0,        32'h5A5A1234, 32'hE08, 4'b1111, 32'h0,        32'h5A5A1234};
    rd_words[0] = 32'h11111111; rd_words[1] = 32'h22222222;
    rd_words[2] = 32'h33333333; rd_words[3] = 32'h44444444;

    // Reset state
    idle_inputs();
    Mem_Ack = 1'b0; Mem_RData = 32'h0; Reset = 1'b1;
    last_rd = 32'h0;
    #12;
    chk("rst_ctrl", {122'b0, Stall, Done, Err, Mem_Req, Mem_We, 1'b0}, 128'd0);
    chk("rst_bus", {60'b0, Mem_BE, Mem_Addr, Mem_WData}, 128'd0);
    chk("rst_rd", {96'b0, ReadData}, 128'd0);
    chk("rst_rd128", ReadData128, 128'd0);
    @(negedge Clock); Reset = 1'b0;

    // Req_Valid without read or write is ignored
    @(negedge Clock);
    Req_Valid = 1'b1; Mem_Ack = 1'b1;
    #1 chk("novalid_stall", {127'b0, Stall}, 128'd0);
    @(negedge Clock);
    idle_inputs();
    chk("novalid_req", {127'b0, Mem_Req}, 128'd0);

    // Table of single-beat transactions (last entry reserved for post-reset)
    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // 128-bit load at 0x41C: four beats, Done in cycle 5
    @(negedge Clock);
    Req_Valid = 1'b1; MemRead = 1'b1; L16B = 2'b01; Address = 32'h41C;
    Mem_Ack = 1'b1; Mem_RData = 32'h0;
    for (int b = 0; b < 4; b++) begin
      @(negedge Clock);
      idle_inputs();
      chk($sformatf("l16_addr%0d", b), {96'b0, Mem_Addr}, {96'b0, 32'h410 + 32'(4 * b)});
      chk($sformatf("l16_busy%0d", b), {125'b0, Mem_Req, Stall, Done}, 128'd6);
      chk($sformatf("l16_be%0d", b), {124'b0, Mem_BE}, 128'hF);
      Mem_RData = rd_words[b];
    end
    @(negedge Clock);
    chk("l16_done", {126'b0, Done, Err}, 128'd2);
    chk("l16_stall", {127'b0, Stall}, 128'd0);
    chk("l16_rd128", ReadData128, 128'h44444444_33333333_22222222_11111111);
    chk("l16_rd", {96'b0, ReadData}, 128'h11111111);
    last_rd = 32'h11111111;

    // Timeout: ack held low, Mem_Req must stay up for exactly 16 cycles
    @(negedge Clock);
    Mem_Ack = 1'b0;
    Req_Valid = 1'b1; MemRead = 1'b1; Address = 32'hD00;
    req_cnt = 0; done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(negedge Clock);
      idle_inputs();
      if (Mem_Req) req_cnt++;
      if (Done) begin
        done_seen = 1'b1;
        chk("tmo_err", {127'b0, Err}, 128'd1);
        chk("tmo_rd", {96'b0, ReadData}, 128'd0);
        chk("tmo_rd128", ReadData128, 128'd0);
        chk("tmo_stall", {126'b0, Stall, Mem_Req}, 128'd0);
      end
    end
    chk("tmo_done_seen", {127'b0, done_seen}, 128'd1);
    chk("tmo_req_cycles", 128'(req_cnt), 128'd16);
    @(negedge Clock);
    chk("tmo_pulse", {126'b0, Done, Err}, 128'd0);
    last_rd = 32'h0;

    // Reset during the second beat of a 128-bit load
    @(negedge Clock);
    Mem_Ack = 1'b1; Mem_RData = 32'hABABABAB;
    Req_Valid = 1'b1; MemRead = 1'b1; L16B = 2'b01; Address = 32'h428;
    @(negedge Clock);
    idle_inputs();
    @(negedge Clock);
    chk("rstmid_addr", {96'b0, Mem_Addr}, 128'h424);
    #2 Reset = 1'b1;
    #1 chk("rstmid_req", {126'b0, Mem_Req, Stall}, 128'd0);
    @(negedge Clock); Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      chk($sformatf("rstmid_nodone%0d", c), {125'b0, Done, Mem_Req, Stall}, 128'd0);
    end
    run_vec(vecs[11], 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
